// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for n digits; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_addsub_digit_adder.sv
// Combinational DIGIT-bit ripple adder built from 1-bit full-adder cells.
module digit_adder
  import serial_addsub_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]       = a[i] ^ b[i] ^ c_s[i];
    assign c_s[i + 1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
  end

  assign cout = c_s[DIGIT];
  assign cmsb = c_s[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract: one DIGIT-bit slice per cycle, LSB slice first,
// result published atomically on the last slice.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] res_shift_s;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic [DIGIT-1:0] dsum_s;
  logic             dcout_s;
  logic             dcmsb_s;
  logic             last_s;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a    (a_r[DIGIT-1:0]),
    .b    (b_r[DIGIT-1:0]),
    .cin  (carry_r),
    .s    (dsum_s),
    .cout (dcout_s),
    .cmsb (dcmsb_s)
  );

  assign last_s = (cnt_r == CW'(NDIG - 1));

  // Slice result enters at the top so the LSB slice ends up at bit 0.
  always_comb begin
    res_shift_s = res_r >> DIGIT;
    res_shift_s[WIDTH-1 -: DIGIT] = dsum_s;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = start ? RUN : IDLE;
      RUN:     state_next_s = last_s ? DONE : RUN;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy = (state_r == RUN);
    done = (state_r == DONE);
  end

  // Operand shifters, carry, digit counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      sum     <= {WIDTH{1'b0}};
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1.
            a_r     <= a;
            b_r     <= b ^ {WIDTH{sub}};
            carry_r <= sub;
            cnt_r   <= {CW{1'b0}};
            res_r   <= {WIDTH{1'b0}};
          end
        end
        RUN: begin
          a_r     <= a_r >> DIGIT;
          b_r     <= b_r >> DIGIT;
          carry_r <= dcout_s;
          res_r   <= res_shift_s;
          cnt_r   <= cnt_r + CW'(1);
          if (last_s) begin
            sum  <= res_shift_s;
            cout <= dcout_s;
            ovf  <= dcout_s ^ dcmsb_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub at DIGIT = 1, 4 and 16 (WIDTH = 16).
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start4, start16;
  logic        sub;
  logic [15:0] a, b;
  logic        busy1, busy4, busy16;
  logic        done1, done4, done16;
  logic [15:0] sum1, sum4, sum16;
  logic        cout1, cout4, cout16;
  logic        ovf1, ovf4, ovf16;

  int vecs = 0;
  int errs = 0;
  logic [15:0] last_sum = 16'h0000;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(16), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a), .b(b),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));
  serial_addsub #(.WIDTH(16), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub), .a(a), .b(b),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4));
  serial_addsub #(.WIDTH(16), .DIGIT(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub), .a(a), .b(b),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One operation on all three instances; operands are scrambled after the start edge.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic ts, input logic [15:0] es, input logic ec, input logic eo);
    int d1, d4, d16, n1, n4, n16;
    logic [17:0] r1, r4, r16;
    logic both;
    d1 = 0; d4 = 0; d16 = 0; n1 = 0; n4 = 0; n16 = 0;
    r1 = '0; r4 = '0; r16 = '0; both = 1'b0;
    @(negedge clk);
    a = ta; b = tb_; sub = ts; start1 = 1'b1; start4 = 1'b1; start16 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0; start16 = 1'b0;
    a = ~ta; b = ~tb_; sub = ~ts;
    chk({tag, "_busy4"}, 32'(busy4), 32'd1);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin
        chk({tag, "_hold4"}, 32'(sum4), 32'(last_sum));
        chk({tag, "_hold1"}, 32'(sum1), 32'(last_sum));
      end
      if ((busy1 && done1) || (busy4 && done4) || (busy16 && done16)) both = 1'b1;
      if (done1)  begin n1++;  if (d1 == 0)  begin d1 = c;  r1 = {cout1, ovf1, sum1};    end end
      if (done4)  begin n4++;  if (d4 == 0)  begin d4 = c;  r4 = {cout4, ovf4, sum4};    end end
      if (done16) begin n16++; if (d16 == 0) begin d16 = c; r16 = {cout16, ovf16, sum16}; end end
    end
    chk({tag, "_lat1"},   32'(d1),  32'd16);
    chk({tag, "_lat4"},   32'(d4),  32'd4);
    chk({tag, "_lat16"},  32'(d16), 32'd1);
    chk({tag, "_npulse"}, 32'(n1 + n4 + n16), 32'd3);
    chk({tag, "_res1"},   32'(r1),  32'({ec, eo, es}));
    chk({tag, "_res4"},   32'(r4),  32'({ec, eo, es}));
    chk({tag, "_res16"},  32'(r16), 32'({ec, eo, es}));
    chk({tag, "_busydone"}, 32'(both), 32'd0);
    last_sum = es;
  endtask

  initial begin
    int n, dc;
    logic [15:0] s_first, s_second;
    rst = 1'b1; start1 = 1'b0; start4 = 1'b0; start16 = 1'b0;
    sub = 1'b0; a = 16'h0000; b = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", 32'({busy4, done4, cout4, ovf4, sum4}), 32'd0);
    chk("rst_outs1", 32'({busy1, done1, cout1, ovf1, sum1}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add_basic", 16'h1234, 16'h0FED, 1'b0, 16'h2221, 1'b0, 1'b0);
    run_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_neg",   16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf",   16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("add_mix",   16'hA5A5, 16'h5A5B, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("sub_eq",    16'h1000, 16'h1000, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op("add_negov", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op("sub_povf",  16'h0003, 16'h8000, 1'b1, 16'h8003, 1'b0, 1'b1);
    run_op("sub_mid",   16'h1234, 16'h4321, 1'b1, 16'hCF13, 1'b0, 1'b0);

    // start held through RUN and DONE with new operands: only the first op counts.
    n = 0; dc = 0; s_first = 16'h0000;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; sub = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (done4) begin n++; dc = c; s_first = sum4; end
      if (c == 5) start4 = 1'b0;
    end
    chk("glitch_npulse", 32'(n), 32'd1);
    chk("glitch_lat", 32'(dc), 32'd4);
    chk("glitch_sum", 32'(s_first), 32'h3333);
    chk("glitch_flags", 32'({cout4, ovf4, busy4}), 32'd0);

    // Start held high: the second op is taken on the first IDLE edge.
    n = 0; dc = 0; s_first = 16'h0000; s_second = 16'h0000;
    @(negedge clk);
    a = 16'h0001; b = 16'h0002; sub = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    a = 16'h0010; b = 16'h0020;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (done4) begin
        n++;
        if (n == 1) s_first = sum4;
        else begin s_second = sum4; dc = c; end
      end
      if (c == 6) start4 = 1'b0;
    end
    chk("b2b_npulse", 32'(n), 32'd2);
    chk("b2b_first", 32'(s_first), 32'h0003);
    chk("b2b_second", 32'(s_second), 32'h0030);
    chk("b2b_lat2", 32'(dc), 32'd10);

    // Reset in the second RUN cycle aborts with no done pulse.
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; sub = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_outs", 32'({busy4, done4, cout4, ovf4, sum4}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (done4) n++;
    end
    chk("abort_nodone", 32'(n), 32'd0);
    chk("abort_sum", 32'(sum4), 32'd0);
    last_sum = 16'h0000;
    run_op("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
